// File: rtl/ram_simple_sp.sv
// ram_simple_sp
// Single-port synchronous RAM with registered read data and a hardware
// clear sequencer that zeroes every word after each reset.
//
// Parameters
//   DATA_WIDTH : word width in bits
//   ADDR_WIDTH : address width in bits, depth = 2**ADDR_WIDTH words
//
// Ports
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   we        : write enable (ignored while init_busy)
//   addr      : shared read/write word address (ignored while init_busy)
//   data_in   : write data
//   data_out  : registered read data, write-first on a write cycle
//   init_busy : high while the clear sequencer is zeroing the array
//
// Build option
//   RAM_OUTREG_EN : adds a second output register, read latency becomes 2.

module ram_simple_sp #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  init_busy
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic                  r_init_busy;
    logic [DATA_WIDTH-1:0] r_rd_data;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_wdata;

    // Clear sequencer: one zero write per clock, busy drops on the edge
    // that writes the last address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_CLEAR;
            r_ptr       <= '0;
            r_init_busy <= 1'b1;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_ptr <= r_ptr + 1'b1;
                    if (r_ptr == {ADDR_WIDTH{1'b1}}) begin
                        r_state     <= ST_RUN;
                        r_init_busy <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_init_busy <= 1'b0;
                end
                default: begin
                    r_state     <= ST_CLEAR;
                    r_ptr       <= '0;
                    r_init_busy <= 1'b1;
                end
            endcase
        end
    end

    // Single write port shared between the sequencer and the user.
    always_comb begin
        w_mem_we    = we;
        w_mem_addr  = addr;
        w_mem_wdata = data_in;
        if (r_init_busy) begin
            w_mem_we    = 1'b1;
            w_mem_addr  = r_ptr;
            w_mem_wdata = '0;
        end
    end

    // Array itself is never reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    // Read register: write-first on a write cycle, held at zero while busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else if (r_init_busy) begin
            r_rd_data <= '0;
        end else if (we) begin
            r_rd_data <= data_in;
        end else begin
            r_rd_data <= r_mem[addr];
        end
    end

`ifdef RAM_OUTREG_EN
    logic [DATA_WIDTH-1:0] r_out_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_pipe <= '0;
        end else if (r_init_busy) begin
            r_out_pipe <= '0;
        end else begin
            r_out_pipe <= r_rd_data;
        end
    end

    assign data_out = r_out_pipe;
`else
    assign data_out = r_rd_data;
`endif

    assign init_busy = r_init_busy;

endmodule

// File: tb/tb_ram_simple_sp.sv
module tb_ram_simple_sp;

    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int DEPTH = 1 << AW;
`ifdef RAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          we = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          init_busy;

    ram_simple_sp #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .init_busy(init_busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] model [DEPTH];

    typedef struct packed {
        logic          chk;
        logic [DW-1:0] exp;
    } sb_t;

    sb_t sbq [$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock of user traffic; the expected read result is queued now and
    // compared LAT edges later.
    task automatic access(input logic w, input int a, input logic [DW-1:0] d, input logic chk);
        sb_t s;
        sb_t e;
        @(negedge clk);
        we      = w;
        addr    = a[AW-1:0];
        data_in = d;
        if (w) begin
            model[a] = d;
            e.exp = d;
        end else begin
            e.exp = model[a];
        end
        e.chk = chk;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        if (sbq.size() >= LAT) begin
            s = sbq.pop_front();
            if (s.chk) check_val(w ? "wr_thru" : "read", data_out, s.exp);
        end
    endtask

    task automatic drain();
        repeat (LAT - 1) access(1'b0, 0, '0, 1'b0);
    endtask

    // Counts edges from release until init_busy falls, trying to write FF to
    // address 3 the whole time. abort_at > 0 pulses reset at that cycle and
    // restarts the count.
    task automatic wait_clear(input int abort_at);
        int cnt;
        cnt = 0;
        we = 1'b1;
        addr = 8'd3;
        data_in = 8'hFF;
        while (init_busy && cnt < 1000) begin
            @(posedge clk);
            #1;
            cnt++;
            if (cnt == 1 || cnt == 128) check_val("busy_dout", data_out, '0);
            if (abort_at > 0 && cnt == abort_at && init_busy) begin
                @(negedge clk);
                rst_n = 1'b0;
                #1;
                check_val("midrst_busy", init_busy, 1);
                check_val("midrst_dout", data_out, '0);
                @(negedge clk);
                rst_n = 1'b1;
                cnt = 0;
                abort_at = 0;
            end
        end
        check_val("clear_cycles", cnt, DEPTH);
    endtask

    task automatic do_reset(input int abort_at);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("rst_dout", data_out, '0);
        check_val("rst_busy", init_busy, 1);
        sbq.delete();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        repeat (2) @(negedge clk);
        check_val("rst_hold_busy", init_busy, 1);
        rst_n = 1'b1;
        wait_clear(abort_at);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = '0;

        // Reset, clear, busy lockout on addr 3, full zero sweep
        do_reset(0);
        for (int i = 0; i < DEPTH; i++) access(1'b0, i, '0, 1'b1);
        drain();

        // Basic write / read
        access(1'b1, 0, 8'h12, 1'b1);
        access(1'b1, 4, 8'h34, 1'b1);
        access(1'b0, 0, '0, 1'b1);
        access(1'b0, 4, '0, 1'b1);
        drain();

        // Write-through
        access(1'b1, 8'h10, 8'hA5, 1'b1);
        access(1'b0, 8'h10, '0, 1'b1);
        drain();

        // Overwrite and hold
        access(1'b1, 4, 8'h34, 1'b1);
        access(1'b1, 4, 8'h56, 1'b1);
        repeat (3) access(1'b0, 4, '0, 1'b1);
        access(1'b0, 0, '0, 1'b1);
        access(1'b0, 3, '0, 1'b1);
        drain();

        // Random mix including top and bottom addresses
        access(1'b1, 255, 8'hC3, 1'b1);
        for (int i = 0; i < 64; i++) begin
            access(($urandom_range(0, 1) == 1), $urandom_range(0, 15) * 17, DW'($urandom), 1'b1);
        end
        access(1'b0, 255, '0, 1'b1);
        drain();

        // Reset while data present, aborted mid-clear at cycle 100
        do_reset(100);
        access(1'b0, 0, '0, 1'b1);
        access(1'b0, 4, '0, 1'b1);
        access(1'b0, 8'h10, '0, 1'b1);
        access(1'b0, 255, '0, 1'b1);
        access(1'b0, 3, '0, 1'b1);
        access(1'b1, 7, 8'h5A, 1'b1);
        access(1'b0, 6, '0, 1'b1);
        access(1'b0, 7, '0, 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ram_simple_sp.md
Name: ram_simple_sp

Overview:
- Single-port synchronous RAM: one address bus shared by reads and writes, registered read data.
- Contents are cleared to zero by a hardware sequencer after every reset.
- Generic scratch storage for datapath blocks; one clock domain.

Parameters:
- DATA_WIDTH, 8, width of each word in bits.
- ADDR_WIDTH, 8, address width in bits; depth = 2**ADDR_WIDTH words.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- we  input  1  write enable, sampled on rising clk.
- addr  input  ADDR_WIDTH  word address for both read and write.
- data_in  input  DATA_WIDTH  write data.
- data_out  output  DATA_WIDTH  registered read data.
- init_busy  output  1  high while the clear sequencer runs; accesses are ignored.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset assertion, asynchronous:
  - data_out = 0 immediately.
  - init_busy = 1 immediately.
  - clear pointer = 0.
  - Memory array contents are not reset directly.
- Clear sequence, starting after rst_n deasserts:
  - Each rising clk writes 0 to mem[ptr], then ptr increments.
  - After the write to address 2**ADDR_WIDTH-1, init_busy drops on that same edge.
  - Total: 2**ADDR_WIDTH cycles, i.e. 256 at default parameters.
- During init_busy:
  - we and addr are ignored and no user write occurs.
  - data_out holds 0.
- Reset asserted mid-clear: the sequence restarts from address 0 after release.
- Normal operation (init_busy = 0), every rising clk:
  - we = 1: mem[addr] <= data_in and data_out <= data_in (write-first / write-through).
  - we = 0: data_out <= mem[addr].
- Read latency: 1 cycle. data_out reflects the address sampled on the previous edge.
- data_out changes only on clock edges or reset, never combinationally from addr.
- Addresses wrap naturally modulo 2**ADDR_WIDTH; there are no out-of-range accesses.
- X or Z on we while idle is not required to be handled.
- Memory is inferable as block RAM: single write port, synchronous read.

Optional Feature:
- Macro: RAM_OUTREG_EN.
- Defined:
  - An extra output pipeline register follows the read register, giving total read latency 2 cycles.
  - The extra register is reset asynchronously to 0 and holds 0 while init_busy = 1.
  - Write-through data also arrives 2 cycles after the write edge.
- Undefined: latency 1 as specified above. Port list is identical in both builds.

Test Plan:
- Reset and clear:
  - Stimulus: assert rst_n = 0 for 2 cycles, release, count cycles.
  - Required: data_out = 0 and init_busy = 1 during reset; init_busy falls exactly 256 clks after release.
  - Required: every address then reads 8'h00.
- Basic write/read:
  - Stimulus: write 8'h12 to addr 0, write 8'h34 to addr 4, then read addr 0 and read addr 4.
  - Required: data_out = 8'h12, then 8'h34, each 1 cycle after its read address is applied.
- Write-through:
  - Stimulus: we = 1, addr 8'h10, data_in 8'hA5.
  - Required: data_out = 8'hA5 after that same edge.
- Overwrite and hold:
  - Stimulus: write 8'h34 to addr 4, then 8'h56 to addr 4, then read addr 4 for 3 cycles.
  - Required: data_out = 8'h56 on all 3 cycles; addr 0 still reads 8'h12.
- Busy lockout:
  - Stimulus: attempt to write 8'hFF to addr 3 while init_busy = 1, then read addr 3 after the clear completes.
  - Required: data_out = 8'h00.
- Mid-clear reset plus RAM_OUTREG_EN:
  - Stimulus: pulse rst_n low at clear cycle 100.
  - Required: init_busy falls 256 clks after the second release.
  - Required: with the macro defined, each read result arrives 2 cycles after its address.
